// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the register-file controller and its storage.
//   - Y86 instruction codes IHALT..IPOPQ (0..11); codes 12..15 are illegal.
//   - Register specifiers: RNONE (4'hF, "no register") and RRSP (%rsp, 4'h4).
//   - Register file geometry and the controller FSM state enum.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int NUM_REGS = 15;
  localparam int WORD_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_WB,
    WR_E,
    WR_M,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/regfile15x64.sv
// regfile15x64: fifteen 64-bit registers (indices 0..14).
//   clock            rising-edge clock for the write port
//   rst_n            asynchronous active-low clear of every entry
//   raddr_a/rdata_a  combinational read port A (RNONE reads as 0)
//   raddr_b/rdata_b  combinational read port B (RNONE reads as 0)
//   we/waddr/wdata   synchronous write port; writes to RNONE are dropped
module regfile15x64
  import y86_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic [3:0]        raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [3:0]        raddr_b,
  output logic [WORD_W-1:0] rdata_b,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] mem [0:NUM_REGS-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != RNONE)) begin
      mem[waddr] <= wdata;
    end
  end

  // Index 15 has no storage behind it, so it reads as zero.
  assign rdata_a = (raddr_a == RNONE) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == RNONE) ? '0 : mem[raddr_b];

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences one Y86 instruction at a time through operand read
// and writeback against a single-write-port register file.
//   clock, rst_n          clock, asynchronous active-low reset
//   dec_valid/dec_ready   decode handshake carrying icode, ra, rb
//   val_a, val_b, rd_valid operands (held until next read) + one-cycle strobe
//   wb_valid/wb_ready     writeback handshake carrying val_e, val_m, cnd
//   wb_done               one-cycle pulse when the instruction retires
//   bad_icode             one-cycle pulse when icode 12..15 is rejected
module regfile_ctrl
  import y86_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  output logic [WORD_W-1:0] val_a,
  output logic [WORD_W-1:0] val_b,
  output logic              rd_valid,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [WORD_W-1:0] val_e,
  input  logic [WORD_W-1:0] val_m,
  input  logic              cnd,
  output logic              wb_done,
  output logic              bad_icode
);

  ctrl_state_t state_reg, state_next;

  logic [3:0]        icode_reg, ra_reg, rb_reg;
  logic [WORD_W-1:0] val_e_reg, val_m_reg;
  logic              cnd_reg;
  logic [WORD_W-1:0] val_a_reg, val_b_reg;
  logic              rd_valid_reg, bad_icode_reg;

  logic              accept, reject;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [WORD_W-1:0] rf_rdata_a, rf_rdata_b;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [WORD_W-1:0] rf_wdata;

  assign accept = (state_reg == IDLE) && dec_valid && (icode <= IPOPQ);
  assign reject = (state_reg == IDLE) && dec_valid && (icode >  IPOPQ);

  // Sources decode from the incoming request so operands are captured on the
  // acceptance edge and are valid during the READ cycle.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = ra;
      IRET, IPOPQ:                    src_a = RRSP;
      default:                        ;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
      default:                        ;
    endcase
  end

  // Destinations decode from the latched instruction; cmovXX needs the
  // condition flag that arrives with writeback.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode_reg)
      IRRMOVQ:                    dst_e = cnd_reg ? rb_reg : RNONE;
      IIRMOVQ, IOPQ:              dst_e = rb_reg;
      ICALL, IRET, IPUSHQ, IPOPQ: dst_e = RRSP;
      default:                    ;
    endcase
    case (icode_reg)
      IMRMOVQ, IPOPQ:             dst_m = ra_reg;
      default:                    ;
    endcase
  end

  // WR_M always follows WR_E, so for popq %rsp the memory value wins.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dst_e;
    rf_wdata = val_e_reg;
    if (state_reg == WR_E) begin
      rf_we = (dst_e != RNONE);
    end else if (state_reg == WR_M) begin
      rf_we    = (dst_m != RNONE);
      rf_waddr = dst_m;
      rf_wdata = val_m_reg;
    end
  end

  regfile15x64 u_rf (
    .clock   (clock),
    .rst_n   (rst_n),
    .raddr_a (src_a),
    .rdata_a (rf_rdata_a),
    .raddr_b (src_b),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dec_ready  = 1'b0;
    wb_ready   = 1'b0;
    wb_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        dec_ready = 1'b1;
        if (accept) state_next = READ;
      end
      READ:    state_next = WAIT_WB;
      WAIT_WB: begin
        wb_ready = 1'b1;
        if (wb_valid) state_next = WR_E;
      end
      WR_E:    state_next = WR_M;
      WR_M:    state_next = DONE;
      DONE: begin
        wb_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      icode_reg     <= IHALT;
      ra_reg        <= RNONE;
      rb_reg        <= RNONE;
      val_e_reg     <= '0;
      val_m_reg     <= '0;
      cnd_reg       <= 1'b0;
      val_a_reg     <= '0;
      val_b_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      bad_icode_reg <= 1'b0;
    end else begin
      rd_valid_reg  <= accept;
      bad_icode_reg <= reject;
      if (accept) begin
        icode_reg <= icode;
        ra_reg    <= ra;
        rb_reg    <= rb;
        val_a_reg <= rf_rdata_a;
        val_b_reg <= rf_rdata_b;
      end
      if ((state_reg == WAIT_WB) && wb_valid) begin
        val_e_reg <= val_e;
        val_m_reg <= val_m;
        cnd_reg   <= cnd;
      end
    end
  end

  assign val_a     = val_a_reg;
  assign val_b     = val_b_reg;
  assign rd_valid  = rd_valid_reg;
  assign bad_icode = bad_icode_reg;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed-vector bench for regfile_ctrl. Register contents
// are observed through rmmovq "probe" instructions, which read ra/rb and
// write nothing. Expected values are hand-computed in the vector list.
module tb_regfile_ctrl;
  import y86_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [3:0]  icode, ra, rb;
  logic [63:0] val_a, val_b;
  logic        rd_valid;
  logic        wb_valid, wb_ready;
  logic [63:0] val_e, val_m;
  logic        cnd;
  logic        wb_done, bad_icode;

  int n_compared   = 0;
  int n_mismatched = 0;

  regfile_ctrl dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .icode     (icode),
    .ra        (ra),
    .rb        (rb),
    .val_a     (val_a),
    .val_b     (val_b),
    .rd_valid  (rd_valid),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .val_e     (val_e),
    .val_m     (val_m),
    .cnd       (cnd),
    .wb_done   (wb_done),
    .bad_icode (bad_icode)
  );

  always #5 clock = ~clock;

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  // hold = 0: wb_valid high from the start (wb_done 5 cycles after accept).
  // hold > 0: wb_valid low for hold WAIT_WB cycles, wb_done 3 cycles later.
  task automatic run_instr(input string tag, input logic [3:0] ic, input logic [3:0] a_sel,
                           input logic [3:0] b_sel, input logic [63:0] ve, input logic [63:0] vm,
                           input logic c, input int hold,
                           input logic [63:0] exp_a, input logic [63:0] exp_b);
    int n;
    int exp_lat;
    exp_lat   = (hold == 0) ? 5 : hold + 4;
    dec_valid = 1'b1;
    icode     = ic;
    ra        = a_sel;
    rb        = b_sel;
    val_e     = ve;
    val_m     = vm;
    cnd       = c;
    wb_valid  = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    n = 1;
    check64({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
    check64({tag, "_val_a"}, val_a, exp_a);
    check64({tag, "_val_b"}, val_b, exp_b);
    while (!wb_done && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 2) check64({tag, "_rd_pulse"}, 64'(rd_valid), 64'd0);
      if (hold > 0 && n >= 2 && n <= hold + 1) begin
        check64({tag, "_wait_ready"}, 64'(wb_ready), 64'd1);
        check64({tag, "_wait_done"}, 64'(wb_done), 64'd0);
        if (n == hold + 1) wb_valid = 1'b1;
      end
    end
    check64({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check64({tag, "_val_a_hold"}, val_a, exp_a);
    wb_valid = 1'b0;
    @(negedge clock);
    check64({tag, "_idle"}, 64'(dec_ready), 64'd1);
    $display("txn %-10s icode=%0d ra=%0h rb=%0h val_a=%0h val_b=%0h cycles=%0d",
             tag, ic, a_sel, b_sel, val_a, val_b, n);
  endtask

  initial begin
    rst_n = 1'b0; dec_valid = 1'b0; icode = 4'h0; ra = RNONE; rb = RNONE;
    wb_valid = 1'b0; val_e = '0; val_m = '0; cnd = 1'b0;
    repeat (2) @(negedge clock);
    check64("rst_dec_ready", 64'(dec_ready), 64'd1);
    check64("rst_wb_ready",  64'(wb_ready),  64'd0);
    check64("rst_rd_valid",  64'(rd_valid),  64'd0);
    check64("rst_wb_done",   64'(wb_done),   64'd0);
    check64("rst_bad",       64'(bad_icode), 64'd0);
    check64("rst_val_a",     val_a, 64'd0);
    check64("rst_val_b",     val_b, 64'd0);
    $display("txn reset      released");
    rst_n = 1'b1;

    // Decode issued in the same half-cycle reset lifts: accepted on the first edge.
    run_instr("irmovq",  IIRMOVQ, RNONE, 4'h2, 64'h1234, 64'h0, 1'b0, 0, 64'h0, 64'h0);
    run_instr("opq",     IOPQ,    4'h2,  4'h2, 64'h2468, 64'h0, 1'b0, 0, 64'h1234, 64'h1234);
    run_instr("cmov_n",  IRRMOVQ, 4'h1,  4'h3, 64'hAA,   64'h0, 1'b0, 0, 64'h0, 64'h0);
    run_instr("probe1",  IRMMOVQ, 4'h3,  4'h2, 64'h0,    64'h0, 1'b0, 0, 64'h0, 64'h2468);
    run_instr("cmov_y",  IRRMOVQ, 4'h1,  4'h3, 64'hAA,   64'h0, 1'b1, 0, 64'h0, 64'h0);
    run_instr("probe2",  IRMMOVQ, 4'h3,  4'h1, 64'h0,    64'h0, 1'b0, 0, 64'hAA, 64'h0);
    run_instr("popq_rsp", IPOPQ,  4'h4,  RNONE, 64'h108, 64'hBEEF, 1'b0, 0, 64'h0, 64'h0);
    run_instr("probe3",  IRMMOVQ, 4'h4,  4'h3, 64'h0,    64'h0, 1'b0, 0, 64'hBEEF, 64'hAA);

    // Illegal icode: rejected in IDLE with a one-cycle bad_icode pulse.
    dec_valid = 1'b1; icode = 4'd13; ra = 4'h2; rb = 4'h2;
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    check64("bad_pulse",    64'(bad_icode), 64'd1);
    check64("bad_dec_rdy",  64'(dec_ready), 64'd1);
    check64("bad_rd_valid", 64'(rd_valid),  64'd0);
    @(negedge clock);
    check64("bad_drop",     64'(bad_icode), 64'd0);
    check64("bad_dec_rdy2", 64'(dec_ready), 64'd1);
    $display("txn bad_icode  icode=13 bad_icode pulsed");
    run_instr("probe4",  IRMMOVQ, 4'h2,  4'h4, 64'h0,    64'h0, 1'b0, 0, 64'h2468, 64'hBEEF);

    run_instr("wait10",  IIRMOVQ, RNONE, 4'h5, 64'h55,   64'h0, 1'b0, 10, 64'h0, 64'h0);
    run_instr("pushq",   IPUSHQ,  4'h5,  RNONE, 64'hBEE7, 64'h0, 1'b0, 0, 64'h55, 64'hBEEF);
    run_instr("halt",    IHALT,   4'h2,  4'h2, 64'h77,   64'h99, 1'b1, 0, 64'h0, 64'h0);
    run_instr("probe5",  IRMMOVQ, 4'h4,  4'h5, 64'h0,    64'h0, 1'b0, 0, 64'hBEE7, 64'h55);

    // Reset asserted during WR_E of mrmovq: the pending writes must be lost.
    dec_valid = 1'b1; icode = IMRMOVQ; ra = 4'h6; rb = 4'h2;
    val_e = 64'h77; val_m = 64'hDEAD; cnd = 1'b0; wb_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dec_valid = 1'b0;
    check64("mr_rd_valid", 64'(rd_valid), 64'd1);
    check64("mr_val_b",    val_b, 64'h2468);
    @(negedge clock);
    check64("mr_wb_ready", 64'(wb_ready), 64'd1);
    @(negedge clock);
    check64("mr_in_wr_e",  64'(dec_ready | wb_ready), 64'd0);
    rst_n = 1'b0;
    wb_valid = 1'b0;
    #1;
    check64("arst_dec_ready", 64'(dec_ready), 64'd1);
    check64("arst_val_b",     val_b, 64'd0);
    check64("arst_rd_valid",  64'(rd_valid), 64'd0);
    repeat (2) begin
      @(negedge clock);
      check64("arst_wb_done", 64'(wb_done), 64'd0);
    end
    $display("txn reset      mid-WR_E of mrmovq");
    rst_n = 1'b1;
    run_instr("probe6",  IRMMOVQ, 4'h2,  4'h4, 64'h0,    64'h0, 1'b0, 0, 64'h0, 64'h0);
    run_instr("probe7",  IRMMOVQ, 4'h6,  4'h5, 64'h0,    64'h0, 1'b0, 0, 64'h0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Port clock  in  1  single clock; all state updates on rising edge.
REQ-002 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 Port dec_valid  in  1  decode request; icode/ra/rb valid.
REQ-004 Port dec_ready  out  1  controller can accept a decode request.
REQ-005 Port icode  in  4  instruction code, Y86 encoding 0..11.
REQ-006 Port ra  in  4  register specifier A; 4'hF = RNONE.
REQ-007 Port rb  in  4  register specifier B; 4'hF = RNONE.
REQ-008 Port val_a  out  64  operand A read from register file.
REQ-009 Port val_b  out  64  operand B read from register file.
REQ-010 Port rd_valid  out  1  one-cycle pulse; val_a/val_b valid.
REQ-011 Port wb_valid  in  1  writeback request; val_e/val_m/cnd valid.
REQ-012 Port wb_ready  out  1  controller can accept writeback.
REQ-013 Port val_e  in  64  execute result for dstE.
REQ-014 Port val_m  in  64  memory result for dstM.
REQ-015 Port cnd  in  1  condition flag; gates cmovXX dstE.
REQ-016 Port wb_done  out  1  one-cycle pulse; instruction retired.
REQ-017 Port bad_icode  out  1  one-cycle pulse; illegal icode (12..15) rejected.

Function
REQ-018 FSM states IDLE, READ, WAIT_WB, WR_E, WR_M, DONE; dec_ready=1 only in IDLE, wb_ready=1 only in WAIT_WB.
REQ-019 IDLE: dec_valid=1 -> latch icode/ra/rb, go READ; icode 12..15 -> pulse bad_icode next cycle, stay IDLE, no read/write.
REQ-020 srcA: icode 2,4,6,10 -> ra; 9,11 -> 4 (%rsp); else RNONE.
REQ-021 srcB: icode 4,5,6 -> rb; 8,9,10,11 -> 4; else RNONE.
REQ-022 dstE: 2 -> rb if cnd else RNONE; 3,6 -> rb; 8,9,10,11 -> 4; else RNONE.
REQ-023 dstM: 5,11 -> ra; else RNONE.
REQ-024 READ: val_a=rf[srcA], val_b=rf[srcB], 0 when source is RNONE; rd_valid pulses in the cycle after acceptance; go WAIT_WB.
REQ-025 val_a/val_b hold until the next READ.
REQ-026 WAIT_WB: wb_valid=1 -> latch val_e/val_m/cnd, go WR_E; otherwise wait indefinitely.
REQ-027 WR_E writes val_e to dstE unless RNONE; WR_M writes val_m to dstM unless RNONE; both states always take one cycle each (fixed latency).
REQ-028 Same-register conflict (popq %rsp): WR_M follows WR_E, so val_m is final.
REQ-029 DONE pulses wb_done, returns IDLE; acceptance-to-wb_done = 5 cycles with wb_valid already high.
REQ-030 Single write port; no read/write overlap, next decode only after DONE, so no bypass needed.
REQ-031 Register index 15 never written; rf holds indices 0..14 only.
REQ-032 icode 0/1 (halt/nop) follow full sequence with no reads and no writes.

Reset
REQ-033 rst_n=0 forces immediately: state IDLE, all rf entries 0, val_a/val_b 0, rd_valid/wb_done/bad_icode 0, latched fields cleared.
REQ-034 Reset mid-operation aborts; no pending write completes after rst_n deasserts.
REQ-035 First decode accepted in the first clock edge after rst_n rises.

Structure
REQ-036 Shared package y86_pkg holds icode constants (IHALT..IPOPQ), RNONE=4'hF, RRSP=4'h4, and the FSM state enum.
REQ-037 Sub-module regfile15x64: 15x64 storage, two combinational read ports, one synchronous write port, async active-low clear.
REQ-038 Source/destination selection is combinational logic inside regfile_ctrl.

Verification
REQ-039 After reset, irmovq (icode 3, rb=2), val_e=0x1234 -> wb_done at +5, then OPq ra=2 rb=2 -> val_a=val_b=0x1234.
REQ-040 cmovXX (icode 2, ra=1, rb=3) with cnd=0, val_e=0xAA -> r3 unchanged; repeat cnd=1 -> r3=0xAA.
REQ-041 popq ra=4 with val_e=0x108, val_m=0xBEEF -> r4=0xBEEF.
REQ-042 icode 13 with dec_valid -> bad_icode pulse, dec_ready stays 1, no register changes.
REQ-043 Hold wb_valid=0 for 10 cycles in WAIT_WB -> wb_ready held 1, no writes, no wb_done; then wb_valid=1 -> wb_done 3 cycles later.
REQ-044 Assert rst_n=0 during WR_E of mrmovq -> all registers 0, state IDLE, no wb_done.
